game_state_tx: RTL and testbench

- Serializes one snapshot of the local game state onto a UART line once per accepted frame_update pulse.
- The snapshot covers game state, timer, score, the local player's pose and the full object grid.
- The block feeds the link to the networking MCU, which distributes state to remote players and the score server.
- It is the transmit end of the state-sync link. The game logic produces the state; this block packetizes and ships it.

---
 rtl/game_state_tx_if.sv | 28 ++
 rtl/game_state_tx.sv | 106 ++++++++++
 tb/tb_game_state_tx.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/game_state_tx_if.sv
// game_state_tx_if: snapshot request inputs and UART/status outputs of the state-sync transmitter
interface game_state_tx_if;
   logic                   frame_update;
   logic                   tx_enable;
   logic [1:0]             local_player_ID;
   logic [2:0]             game_state;
   logic [7:0]             time_left;
   logic [9:0]             point_total;
   logic [1:0]             player_direction;
   logic [8:0]             player_loc_x;
   logic [8:0]             player_loc_y;
   logic [3:0]             player_state;
   logic [7:0][12:0][3:0]  object_grid;
   logic                   tx;
   logic                   busy;
   logic                   frame_done;
   logic [7:0]             frames_dropped;
   modport master (
      output frame_update, tx_enable, local_player_ID, game_state, time_left, point_total,
             player_direction, player_loc_x, player_loc_y, player_state, object_grid,
      input  tx, busy, frame_done, frames_dropped
   );
   modport slave (
      input  frame_update, tx_enable, local_player_ID, game_state, time_left, point_total,
             player_direction, player_loc_x, player_loc_y, player_state, object_grid,
      output tx, busy, frame_done, frames_dropped
   );
endinterface

// File: rtl/game_state_tx.sv
// game_state_tx: latches a game-state snapshot and sends it as a 61-byte UART 8N1 packet
module game_state_tx #(
   parameter int          CLKS_PER_BIT = 868,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input  logic            clock,
   input  logic            reset,
   game_state_tx_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t          state;
   logic [15:0]     cnt;
   logic [2:0]      bit_idx;
   logic [5:0]      byte_idx, nxt_idx, grid_k;
   logic [7:0]      shreg, chk, cur_byte;
   logic            bit_end;
   logic [1:0]      s_id, s_dir;
   logic [2:0]      s_gs;
   logic [7:0]      s_time;
   logic [9:0]      s_pts;
   logic [8:0]      s_x, s_y;
   logic [3:0]      s_pst;
   logic [51:0][7:0] s_grid;
   assign bit_end = cnt == 16'(CLKS_PER_BIT - 1);
   assign nxt_idx = byte_idx + 6'd1;
   assign grid_k  = nxt_idx - 6'd8;
   // mux selects the byte about to be loaded, i.e. the one after byte_idx
   always_comb begin
      cur_byte = s_grid[grid_k];
      case (nxt_idx)
         6'd1:    cur_byte = {s_id, 3'b000, s_gs};
         6'd2:    cur_byte = s_time;
         6'd3:    cur_byte = s_pts[7:0];
         6'd4:    cur_byte = {s_dir, s_pst, s_pts[9:8]};
         6'd5:    cur_byte = s_x[7:0];
         6'd6:    cur_byte = s_y[7:0];
         6'd7:    cur_byte = {6'b0, s_y[8], s_x[8]};
         6'd60:   cur_byte = chk;
         default: ;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state              <= IDLE;
         cnt                <= '0;
         bit_idx            <= '0;
         byte_idx           <= '0;
         shreg              <= '0;
         chk                <= '0;
         bus.tx             <= 1'b1;
         bus.busy           <= 1'b0;
         bus.frame_done     <= 1'b0;
         bus.frames_dropped <= '0;
      end else begin
         bus.frame_done <= 1'b0;
         if (bus.frame_update && bus.tx_enable && bus.busy && bus.frames_dropped != 8'hFF)
            bus.frames_dropped <= bus.frames_dropped + 8'd1;
         cnt <= (state == IDLE || bit_end) ? '0 : cnt + 16'd1;
         case (state)
            IDLE: if (bus.frame_update && bus.tx_enable && !bus.busy) begin
               s_id     <= bus.local_player_ID;
               s_gs     <= bus.game_state;
               s_time   <= bus.time_left;
               s_pts    <= bus.point_total;
               s_dir    <= bus.player_direction;
               s_x      <= bus.player_loc_x;
               s_y      <= bus.player_loc_y;
               s_pst    <= bus.player_state;
               s_grid   <= bus.object_grid;
               state    <= START;
               bus.busy <= 1'b1;
               bus.tx   <= 1'b0;
               byte_idx <= '0;
               chk      <= '0;
               shreg    <= SYNC_BYTE;
            end
            START: if (bit_end) begin
               state   <= DATA;
               bit_idx <= '0;
               bus.tx  <= shreg[0];
               shreg   <= shreg >> 1;
            end
            DATA: if (bit_end) begin
               bit_idx <= bit_idx + 3'd1;
               bus.tx  <= (bit_idx == 3'd7) ? 1'b1 : shreg[0];
               shreg   <= shreg >> 1;
               if (bit_idx == 3'd7) state <= STOP;
            end
            STOP: if (bit_end) begin
               if (byte_idx < 6'd60) begin
                  byte_idx <= nxt_idx;
                  state    <= START;
                  bus.tx   <= 1'b0;
                  shreg    <= cur_byte;
                  if (nxt_idx != 6'd60) chk <= chk ^ cur_byte;
               end else begin
                  state          <= IDLE;
                  bus.busy       <= 1'b0;
                  bus.frame_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_game_state_tx.sv
// tb_game_state_tx: scoreboard bench, expected packet bytes queued at request, UART monitor pops and compares
module tb_game_state_tx;
   localparam int C = 4;
   logic clock = 1'b0;
   logic reset = 1'b1;
   game_state_tx_if bus();
   game_state_tx #(.CLKS_PER_BIT(C), .SYNC_BYTE(8'hA5)) dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;
   int checks = 0, failures = 0, epoch = 0, rx_bytes = 0, fd_cnt = 0;
   logic [7:0] exp_q [$];
   always @(negedge clock) if (bus.frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic request();
      @(negedge clock);
      bus.frame_update = 1'b1;
      @(negedge clock);
      bus.frame_update = 1'b0;
   endtask
   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (bus.frame_done !== 1'b1 && n < 4000);
   endtask
   task automatic set_vec(input logic [1:0] id, input logic [2:0] gs, input logic [7:0] tl,
                          input logic [9:0] pt, input logic [1:0] dir, input logic [3:0] ps,
                          input logic [8:0] x, input logic [8:0] y);
      bus.local_player_ID = id;   bus.game_state = gs;     bus.time_left = tl;
      bus.point_total = pt;       bus.player_direction = dir; bus.player_state = ps;
      bus.player_loc_x = x;       bus.player_loc_y = y;
   endtask
   task automatic rand_grid();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 13; c++) bus.object_grid[r][c] = 4'($urandom);
   endtask
   // reference packet built from the cell numbering n = row*13 + col
   task automatic push_model();
      logic [7:0] b [61];
      logic [7:0] x8;
      int n0, n1;
      b[0] = 8'hA5;
      b[1] = {bus.local_player_ID, 3'b000, bus.game_state};
      b[2] = bus.time_left;
      b[3] = bus.point_total[7:0];
      b[4] = {bus.player_direction, bus.player_state, bus.point_total[9:8]};
      b[5] = bus.player_loc_x[7:0];
      b[6] = bus.player_loc_y[7:0];
      b[7] = {6'b0, bus.player_loc_y[8], bus.player_loc_x[8]};
      for (int k = 0; k < 52; k++) begin
         n0 = 2 * k;
         n1 = 2 * k + 1;
         b[8 + k] = {bus.object_grid[n1 / 13][n1 % 13], bus.object_grid[n0 / 13][n0 % 13]};
      end
      x8 = 8'h00;
      for (int i = 1; i < 60; i++) x8 = x8 ^ b[i];
      b[60] = x8;
      for (int i = 0; i < 61; i++) exp_q.push_back(b[i]);
   endtask
   task automatic push_hand1();
      logic [7:0] h [61];
      for (int i = 0; i < 61; i++) h[i] = 8'h00;
      h[0] = 8'hA5; h[1] = 8'h42; h[2] = 8'h96; h[3] = 8'hA5;
      h[4] = 8'h4E; h[5] = 8'h30; h[6] = 8'hD0; h[7] = 8'h03;
      h[21] = 8'h01; h[53] = 8'h03; h[60] = 8'hDE;
      for (int i = 0; i < 61; i++) exp_q.push_back(h[i]);
   endtask
   initial begin : monitor
      logic [7:0] b;
      int ep;
      forever begin
         @(negedge clock);
         if (!reset && bus.tx === 1'b0) begin
            ep = epoch;
            repeat (C / 2) @(negedge clock);
            for (int i = 0; i < 8; i++) begin
               repeat (C) @(negedge clock);
               b[i] = bus.tx;
            end
            repeat (C) @(negedge clock);
            if (ep == epoch) begin
               check("stop_bit", 32'(bus.tx), 32'd1);
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_byte: got %0h expected none", b);
               end else check($sformatf("rx_byte%0d", rx_bytes), 32'(b), 32'(exp_q.pop_front()));
               rx_bytes++;
            end
         end
      end
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int n, fd0;
      logic low_seen;
      bus.frame_update = 1'b0;
      bus.tx_enable = 1'b1;
      bus.object_grid = '0;
      set_vec(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clock);
      check("rst_tx", 32'(bus.tx), 32'd1);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_frame_done", 32'(bus.frame_done), 32'd0);
      check("rst_dropped", 32'(bus.frames_dropped), 32'd0);
      reset = 1'b0;
      fd0 = fd_cnt;
      low_seen = 1'b0;
      repeat (100) begin
         @(negedge clock);
         if (bus.tx !== 1'b1 || bus.busy !== 1'b0) low_seen = 1'b1;
      end
      check("idle_quiet", 32'(low_seen), 32'd0);
      check("idle_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
      check("idle_dropped", 32'(bus.frames_dropped), 32'd0);
      bus.object_grid[2][0] = 4'd1;
      bus.object_grid[6][12] = 4'd3;
      set_vec(2'd1, 3'd2, 8'd150, 10'h2A5, 2'd1, 4'd3, 9'd304, 9'd464);
      push_hand1();
      request();
      check("p1_busy_rise", 32'(bus.busy), 32'd1);
      check("p1_start_bit", 32'(bus.tx), 32'd0);
      wait_done(n);
      check("p1_latency", 32'(n), 32'd2440);
      check("p1_busy_fall", 32'(bus.busy), 32'd0);
      @(negedge clock);
      check("p1_done_pulse_width", 32'(bus.frame_done), 32'd0);
      set_vec(2'd2, 3'd5, 8'd42, 10'h3C7, 2'd2, 4'hA, 9'h0FF, 9'h101);
      rand_grid();
      push_model();
      request();
      n = 0;
      do begin
         @(negedge clock);
         n++;
         bus.frame_update = (n == 300 || n == 600 || n == 900 || n == 2439 || n == 2440);
         if (n == 1000) begin
            check("p2_dropped3", 32'(bus.frames_dropped), 32'd3);
            set_vec(2'd3, 3'd7, 8'd1, 10'h155, 2'd3, 4'h5, 9'h1AB, 9'h0CD);
            rand_grid();
         end
      end while (bus.frame_done !== 1'b1 && n < 4000);
      check("p2_latency", 32'(n), 32'd2440);
      push_model();
      @(negedge clock);
      bus.frame_update = 1'b0;
      check("p3_back_to_back_busy", 32'(bus.busy), 32'd1);
      check("p2_done_cycle_drop", 32'(bus.frames_dropped), 32'd4);
      repeat (300) begin
         @(negedge clock);
         bus.frame_update = 1'b1;
         @(negedge clock);
         bus.frame_update = 1'b0;
      end
      check("p3_dropped_saturate", 32'(bus.frames_dropped), 32'd255);
      wait_done(n);
      check("p3_latency", 32'(n), 32'd1840);
      set_vec(2'd0, 3'd1, 8'd77, 10'h0F0, 2'd0, 4'h9, 9'h010, 9'h1FF);
      rand_grid();
      push_model();
      request();
      repeat (420) @(negedge clock);
      reset = 1'b1;
      exp_q.delete();
      epoch++;
      @(negedge clock);
      check("abort_tx", 32'(bus.tx), 32'd1);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_dropped", 32'(bus.frames_dropped), 32'd0);
      reset = 1'b0;
      repeat (60) @(negedge clock);
      bus.tx_enable = 1'b0;
      repeat (3) request();
      repeat (5) @(negedge clock);
      check("disabled_busy", 32'(bus.busy), 32'd0);
      check("disabled_tx", 32'(bus.tx), 32'd1);
      check("disabled_dropped", 32'(bus.frames_dropped), 32'd0);
      bus.tx_enable = 1'b1;
      set_vec(2'd2, 3'd3, 8'd200, 10'h301, 2'd1, 4'h6, 9'h123, 9'h045);
      rand_grid();
      push_model();
      request();
      check("p5_busy_rise", 32'(bus.busy), 32'd1);
      wait_done(n);
      check("p5_latency", 32'(n), 32'd2440);
      repeat (50) @(negedge clock);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("rx_byte_count", 32'(rx_bytes), 32'd254);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
